// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared register offsets, bit indices and reset constants for the MMIO port block
package mmio_pkg;

    // Word offsets within the 64-byte window, selected by Address[5:2]
    localparam logic [3:0] OFF_PORT_OUT = 4'h0;
    localparam logic [3:0] OFF_PORT_IN  = 4'h1;
    localparam logic [3:0] OFF_STATUS   = 4'h2;
    localparam logic [3:0] OFF_TIMER    = 4'h3;
    localparam logic [3:0] OFF_CMP      = 4'h4;
    localparam logic [3:0] OFF_CTRL     = 4'h5;

    // STATUS bit positions
    localparam int ST_IN_CHANGED  = 0;
    localparam int ST_TIMER_MATCH = 1;
    localparam int ST_IRQ_EN_LO   = 8;
    localparam int ST_IRQ_EN_HI   = 9;

    // CTRL bit positions
    localparam int CTRL_RUN            = 0;
    localparam int CTRL_CLEAR_ON_MATCH = 1;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_input_sync.sv
// rtl/mmio_input_sync.sv - PortIn synchronizer with last-value register and change detect
//
// Ports:
//   clk, reset      core clock, synchronous active-low reset
//   port_in[7:0]    asynchronous external pins
//   sync_out[7:0]   synchronized pin value
//   changed         high while sync_out differs from the previously captured value
module mmio_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_in,
    output logic [7:0] sync_out,
    output logic       changed
);

    logic [7:0] chain [SYNC_STAGES];
    logic [7:0] in_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= 8'h00;
            end
            in_last <= 8'h00;
        end else begin
            chain[0] <= port_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            in_last <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];
    // Evaluated before in_last catches up, so the parent sets its flag on exactly this edge
    assign changed  = (sync_out != in_last);

endmodule

// File: rtl/mmio_port_controller.sv
// rtl/mmio_port_controller.sv - MEM-stage MMIO decode, RAM strobe gating and I/O register bank
//
// Ports:
//   clk, reset                  core clock, synchronous active-low reset
//   Address/WriteData           EX/MEM byte address and store data
//   MemWrite/MemRead            EX/MEM strobes
//   RAMReadData                 data RAM read data
//   RAMMemWrite/RAMMemRead      strobes to the RAM, suppressed on MMIO hits and during reset
//   ReadData                    load data to MEM/WB (register bank or RAM)
//   PortIn/PortOut              external pins
//   IRQ                         registered level interrupt
module mmio_port_controller
    import mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] RAMReadData,
    output logic        RAMMemWrite,
    output logic        RAMMemRead,
    output logic [31:0] ReadData,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        IRQ
);

    logic        hit;
    logic [3:0]  word;
    logic        wr_en;
    logic [7:0]  sync_in;
    logic        in_changed_evt;
    logic        match_evt;
    logic [1:0]  flags;
    logic [1:0]  irq_en;
    logic [1:0]  ctrl;
    logic [31:0] timer;
    logic [31:0] cmp;
    logic [31:0] reg_rdata;
    logic [1:0]  w1c;
    logic        unused_bits;

    assign hit   = (Address[31:6] == MMIO_BASE[31:6]);
    assign word  = Address[5:2];
    assign wr_en = MemWrite && hit;

    assign RAMMemWrite = reset && MemWrite && !hit;
    assign RAMMemRead  = reset && MemRead && !hit;

    assign unused_bits = &{1'b0, Address[1:0]};

    mmio_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_input_sync (
        .clk      (clk),
        .reset    (reset),
        .port_in  (PortIn),
        .sync_out (sync_in),
        .changed  (in_changed_evt)
    );

    assign match_evt = ctrl[CTRL_RUN] && (timer == cmp);
    assign w1c       = (wr_en && word == OFF_STATUS) ? WriteData[1:0] : 2'b00;

    always_comb begin
        reg_rdata = 32'h0;
        case (word)
            OFF_PORT_OUT: reg_rdata = PortOut;
            OFF_PORT_IN:  reg_rdata = {24'h0, sync_in};
            OFF_STATUS:   reg_rdata = {22'h0, irq_en, 6'h0, flags};
            OFF_TIMER:    reg_rdata = timer;
            OFF_CMP:      reg_rdata = cmp;
            OFF_CTRL:     reg_rdata = {30'h0, ctrl};
            default:      reg_rdata = 32'h0;
        endcase
    end

    assign ReadData = hit ? reg_rdata : RAMReadData;

    always_ff @(posedge clk) begin
        if (!reset) begin
            PortOut <= 32'h0;
            flags   <= 2'b00;
            irq_en  <= 2'b00;
            ctrl    <= 2'b00;
            timer   <= 32'h0;
            cmp     <= CMP_RESET;
            IRQ     <= 1'b0;
        end else begin
            if (wr_en && word == OFF_PORT_OUT) PortOut <= WriteData;
            if (wr_en && word == OFF_CMP)      cmp     <= WriteData;
            if (wr_en && word == OFF_CTRL)     ctrl    <= WriteData[1:0];
            if (wr_en && word == OFF_STATUS)   irq_en  <= WriteData[ST_IRQ_EN_HI:ST_IRQ_EN_LO];

            // Hardware set is OR'd in after the W1C mask so a coincident set survives
            flags[ST_IN_CHANGED]  <= (flags[ST_IN_CHANGED] & ~w1c[ST_IN_CHANGED]) | in_changed_evt;
            flags[ST_TIMER_MATCH] <= (flags[ST_TIMER_MATCH] & ~w1c[ST_TIMER_MATCH]) | match_evt;

            // Software write has priority over the running increment
            if (wr_en && word == OFF_TIMER) begin
                timer <= WriteData;
            end else if (ctrl[CTRL_RUN]) begin
                if (match_evt && ctrl[CTRL_CLEAR_ON_MATCH]) timer <= 32'h0;
                else                                         timer <= timer + 32'h1;
            end

            // Built from the current flags, so IRQ trails a flag change by one cycle
            IRQ <= |(flags & irq_en);
        end
    end

endmodule

// File: doc/mmio_port_controller.md
Name: mmio_port_controller

Overview:
Memory-mapped I/O stage in the MEM stage of the pipelined core, between the EX/MEM register outputs and the data RAM / MEM/WB register. It decodes each data access and routes it either to the data RAM or to a small register bank. The bank holds PortOut, a synchronized PortIn with change detection, and a 32-bit compare timer with an interrupt line. It drives the processor's PortOut and PortIn pins directly.

Parameters:
MMIO_BASE, 32'hFFFF_0000, base byte address of the I/O register window (64-byte window, bits [5:2] select the register)
SYNC_STAGES, 2, flip-flop stages on PortIn (legal values 2..3)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset
Address  in  32  byte address from EX/MEM ALU result
WriteData  in  32  store data from EX/MEM
MemWrite  in  1  store strobe from EX/MEM
MemRead  in  1  load strobe from EX/MEM
RAMReadData  in  32  read data returned by the data RAM
RAMMemWrite  out  1  MemWrite gated to the RAM (0 when the access hits MMIO)
RAMMemRead  out  1  MemRead gated to the RAM
ReadData  out  32  load data to MEM/WB (RAM or MMIO, muxed)
PortIn  in  8  external asynchronous input pins
PortOut  out  32  external output register
IRQ  out  1  level interrupt request

Behaviour:
- Reset: one clk edge with reset==0 clears every register. PortOut=0, sync chain=0, IN_LAST=0, STATUS=0, TIMER=0, CMP=32'hFFFF_FFFF, CTRL=0. IRQ=0.
- Decode: hit = (Address[31:6] == MMIO_BASE[31:6]). On a hit, RAMMemWrite=RAMMemRead=0. On a miss, both pass through unchanged.
- ReadData is combinational in the same cycle: hit ? register[Address[5:2]] : RAMReadData. Unmapped offsets read 0. MemRead=0 on a hit returns the register value with no side effects.
- Register map (word offsets):
  - 0x00 PORT_OUT: RW, 32 bits.
  - 0x04 PORT_IN: RO, {24'b0, synchronized PortIn}.
  - 0x08 STATUS: bit0 in_changed, bit1 timer_match, both W1C. bits[9:8] irq_enable, RW.
  - 0x0C TIMER: RW count.
  - 0x10 CMP: RW.
  - 0x14 CTRL: bit0 run, bit1 clear_on_match.
- Writes: take effect on the clk edge when MemWrite && hit. The whole word is written. Writes to RO or unmapped offsets are ignored.
- PortIn path: SYNC_STAGES-deep synchronizer, then IN_LAST register. in_changed sets on the edge where sync_out != IN_LAST.
- Timer:
  - If run=1, TIMER increments by 1 each cycle and wraps 32'hFFFF_FFFF->0.
  - On the edge where TIMER==CMP and run=1, timer_match sets.
  - If clear_on_match=1, the next TIMER value is 0 instead of CMP+1.
- Simultaneous events:
  - Hardware set and W1C of the same STATUS bit in one cycle: set wins, bit stays 1.
  - A software write to TIMER in the same cycle as an increment: the write wins.
- IRQ = |(STATUS[1:0] & STATUS[9:8]), registered (one-cycle latency from the flag update).
- Reset mid-operation: all state cleared regardless of a pending access. No RAM strobe is asserted while reset==0.

Decomposition:
- Shared package mmio_pkg:
  - register offset constants (OFF_PORT_OUT..OFF_CTRL)
  - STATUS/CTRL bit-index constants
  - CMP reset value
- One sub-module, mmio_input_sync: synchronizer, IN_LAST register, change pulse.
- Timer and register bank stay in the top.

Test Plan:
- Reset, then store 0xDEAD_BEEF to 0xFFFF_0000 -> PortOut=0xDEAD_BEEF on the next edge; RAMMemWrite=0 during that cycle; load of 0xFFFF_0000 returns 0xDEAD_BEEF.
- Store to 0x1001_0004 with RAMReadData driven to 0x1234 and MemRead=1 -> RAMMemWrite/RAMMemRead pass through; ReadData=0x1234.
- PortIn 0x00->0xA5 -> PORT_IN reads 0xA5 after 2 edges; STATUS bit0=1 one edge later. Storing 1 to 0xFFFF_0008 bit0 clears it; holding PortIn stable keeps it clear.
- CMP=5, CTRL=3, irq_enable bit1=1 -> timer_match sets when TIMER reaches 5, TIMER returns to 0, IRQ=1 one cycle later. Repeats every 6 cycles.
- W1C of timer_match in the same cycle as a new match -> bit remains 1, IRQ stays 1.
- Assert reset=0 for one edge mid-count (TIMER=3, PortOut=0xFF) -> all registers back to reset values, IRQ=0, CMP=0xFFFF_FFFF.
